// File: rtl/vrf_banked_stream.sv
`timescale 1ns/1ps
// Banked vector register file with one streaming read port and one streaming write port.
// Define VRF_RESET_CLEAR_EN to zero every row after reset before requests are accepted.
module vrf_banked_stream #(
   parameter int NUM_VRS      = 32,
   parameter int ELEMS_PER_VR = 32,
   parameter int NUM_BANKS    = 4,
   parameter int DATA_WIDTH   = 32,
   localparam int BEATS       = ELEMS_PER_VR / NUM_BANKS,
   localparam int ROWS        = NUM_VRS * BEATS,
   localparam int VRW         = $clog2(NUM_VRS),
   localparam int BW          = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            rd_req_valid,
   output logic                            rd_req_ready,
   input  logic [VRW-1:0]                  rd_req_vr,
   output logic                            rd_valid,
   output logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data,
   output logic [BW-1:0]                   rd_beat,
   output logic                            rd_last,
   input  logic                            wr_req_valid,
   output logic                            wr_req_ready,
   input  logic [VRW-1:0]                  wr_req_vr,
   input  logic                            wr_valid,
   output logic                            wr_ready,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0] wr_data,
   input  logic [NUM_BANKS-1:0]            wr_be,
   output logic                            wr_done
);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int DW = NUM_BANKS * DATA_WIDTH;

   typedef enum logic {R_IDLE, R_BUSY} rstate_e;
   typedef enum logic {W_IDLE, W_BUSY} wstate_e;

   rstate_e r_rstate, w_rstate_nxt;
   wstate_e r_wstate, w_wstate_nxt;
   logic [BW-1:0]  r_rbeat, w_rbeat_nxt, r_wbeat, w_wbeat_nxt;
   logic [VRW-1:0] r_rd_vr, w_rd_vr_nxt, r_wr_vr, w_wr_vr_nxt;

   logic [DATA_WIDTH-1:0] r_mem [NUM_BANKS][ROWS];

   logic          r_rd_valid, r_rd_last, r_wr_done;
   logic [BW-1:0] r_rd_beat;
   logic [DW-1:0] r_rd_data, w_row_data;

   logic          w_clearing, w_clr_we;
   logic [RW-1:0] w_clr_row, w_rrow, w_wrow;
   logic          w_rd_fire, w_wrq_fire, w_wr_fire, w_rlast, w_wlast;

`ifdef VRF_RESET_CLEAR_EN
   logic          r_clearing;
   logic [RW-1:0] r_clr_row;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_clearing <= 1'b1;
         r_clr_row  <= '0;
      end else if (r_clearing) begin
         r_clr_row <= r_clr_row + RW'(1);
         if (r_clr_row == RW'(ROWS - 1)) r_clearing <= 1'b0;
      end
   end

   assign w_clearing = r_clearing;
   assign w_clr_we   = r_clearing & ~rst;
   assign w_clr_row  = r_clr_row;
`else
   assign w_clearing = 1'b0;
   assign w_clr_we   = 1'b0;
   assign w_clr_row  = '0;
`endif

   // A same-VR read accepted this cycle takes priority over a write request.
   assign rd_req_ready = ~rst & ~w_clearing & (r_rstate == R_IDLE)
                       & ~((r_wstate == W_BUSY) && (r_wr_vr == rd_req_vr));
   assign w_rd_fire    = rd_req_valid & rd_req_ready;
   assign wr_req_ready = ~rst & ~w_clearing & (r_wstate == W_IDLE)
                       & ~((r_rstate == R_BUSY) && (r_rd_vr == wr_req_vr))
                       & ~(w_rd_fire && (rd_req_vr == wr_req_vr));
   assign w_wrq_fire   = wr_req_valid & wr_req_ready;
   assign wr_ready     = ~rst & (r_wstate == W_BUSY);
   assign w_wr_fire    = wr_valid & wr_ready;

   assign w_rlast = (r_rbeat == BW'(BEATS - 1));
   assign w_wlast = (r_wbeat == BW'(BEATS - 1));
   assign w_rrow  = RW'(r_rd_vr) * RW'(BEATS) + RW'(r_rbeat);
   assign w_wrow  = RW'(r_wr_vr) * RW'(BEATS) + RW'(r_wbeat);

   always_comb begin
      w_rstate_nxt = r_rstate;
      w_rbeat_nxt  = r_rbeat;
      w_rd_vr_nxt  = r_rd_vr;
      unique case (r_rstate)
         R_IDLE: begin
            if (w_rd_fire) begin
               w_rstate_nxt = R_BUSY;
               w_rbeat_nxt  = '0;
               w_rd_vr_nxt  = rd_req_vr;
            end
         end
         R_BUSY: begin
            w_rbeat_nxt = r_rbeat + BW'(1);
            if (w_rlast) begin
               w_rstate_nxt = R_IDLE;
               w_rbeat_nxt  = '0;
            end
         end
      endcase
   end

   always_comb begin
      w_wstate_nxt = r_wstate;
      w_wbeat_nxt  = r_wbeat;
      w_wr_vr_nxt  = r_wr_vr;
      unique case (r_wstate)
         W_IDLE: begin
            if (w_wrq_fire) begin
               w_wstate_nxt = W_BUSY;
               w_wbeat_nxt  = '0;
               w_wr_vr_nxt  = wr_req_vr;
            end
         end
         W_BUSY: begin
            if (w_wr_fire) begin
               w_wbeat_nxt = r_wbeat + BW'(1);
               if (w_wlast) begin
                  w_wstate_nxt = W_IDLE;
                  w_wbeat_nxt  = '0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rstate <= R_IDLE;
         r_rbeat  <= '0;
         r_rd_vr  <= '0;
         r_wstate <= W_IDLE;
         r_wbeat  <= '0;
         r_wr_vr  <= '0;
      end else begin
         r_rstate <= w_rstate_nxt;
         r_rbeat  <= w_rbeat_nxt;
         r_rd_vr  <= w_rd_vr_nxt;
         r_wstate <= w_wstate_nxt;
         r_wbeat  <= w_wbeat_nxt;
         r_wr_vr  <= w_wr_vr_nxt;
      end
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (w_clr_we) begin
            r_mem[b][w_clr_row] <= '0;
         end else if (w_wr_fire && wr_be[b]) begin
            r_mem[b][w_wrow] <= wr_data[b*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      w_row_data = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         w_row_data[b*DATA_WIDTH +: DATA_WIDTH] = r_mem[b][w_rrow];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
         r_rd_beat  <= '0;
         r_rd_data  <= '0;
         r_wr_done  <= 1'b0;
      end else begin
         r_rd_valid <= (r_rstate == R_BUSY);
         r_rd_last  <= (r_rstate == R_BUSY) && w_rlast;
         r_rd_beat  <= (r_rstate == R_BUSY) ? r_rbeat : '0;
         r_rd_data  <= (r_rstate == R_BUSY) ? w_row_data : '0;
         r_wr_done  <= w_wr_fire && w_wlast;
      end
   end

   assign rd_valid = r_rd_valid;
   assign rd_last  = r_rd_last;
   assign rd_beat  = r_rd_beat;
   assign rd_data  = r_rd_data;
   assign wr_done  = r_wr_done;

endmodule

// File: tb/tb_vrf_banked_stream.sv
`timescale 1ns/1ps
// Directed bench for vrf_banked_stream at default parameters (8 beats of 4x32-bit elements).
module tb_vrf_banked_stream;
   logic         clk = 1'b0;
   logic         rst;
   logic         rd_req_valid, rd_req_ready, rd_valid, rd_last;
   logic [4:0]   rd_req_vr, wr_req_vr;
   logic [127:0] rd_data, wr_data;
   logic [2:0]   rd_beat;
   logic         wr_req_valid, wr_req_ready, wr_valid, wr_ready, wr_done;
   logic [3:0]   wr_be;

   vrf_banked_stream dut (
      .clk          (clk),
      .rst          (rst),
      .rd_req_valid (rd_req_valid),
      .rd_req_ready (rd_req_ready),
      .rd_req_vr    (rd_req_vr),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .rd_beat      (rd_beat),
      .rd_last      (rd_last),
      .wr_req_valid (wr_req_valid),
      .wr_req_ready (wr_req_ready),
      .wr_req_vr    (wr_req_vr),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_data      (wr_data),
      .wr_be        (wr_be),
      .wr_done      (wr_done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: only ever increments, tests work on deltas.
   logic [127:0] cap [8];
   int mon_en = 0, beats_tot = 0, last_tot = 0, done_tot = 0, bbad_tot = 0, zero_bad = 0;
   int last_beat = 0, last_cyc = 0, exp_beat = 0;
   always @(negedge clk) begin
      if (rst) exp_beat = 0;
      else if (mon_en != 0) begin
         if (rd_valid) begin
            if (int'(rd_beat) != exp_beat) bbad_tot++;
            cap[rd_beat] = rd_data;
            beats_tot++;
            exp_beat = (exp_beat + 1) % 8;
            if (rd_last) begin
               last_tot++;
               last_beat = int'(rd_beat);
               last_cyc  = cyc;
            end
         end else if (rd_data !== '0 || rd_last) begin
            zero_bad++;
         end
         if (wr_done) done_tot++;
      end
   end

   logic [127:0] wdata [8];
   logic [3:0]   wbe_a [8];
   logic [127:0] expd  [8];
   int stall_beat = -1;
   int s_beats, s_last, s_done, s_bbad;

   task automatic snap();
      s_beats = beats_tot; s_last = last_tot; s_done = done_tot; s_bbad = bbad_tot;
   endtask

   task automatic set_pat(input logic [31:0] base);
      for (int k = 0; k < 8; k++) begin
         wdata[k] = {4{base + 32'(k)}};
         wbe_a[k] = 4'hF;
      end
   endtask

   task automatic read_vec(input int vr, output int acc, output int waited);
      int t;
      t = 0;
      @(posedge clk); #1;
      rd_req_valid = 1'b1; rd_req_vr = 5'(vr);
      @(negedge clk);
      while (!rd_req_ready && t < 1000) begin @(negedge clk); t++; end
      if (t >= 1000) check("rd_req_timeout", 0, 1);
      acc = cyc; waited = t;
      @(posedge clk); #1;
      rd_req_valid = 1'b0;
      t = 0;
      @(negedge clk);
      while (!(rd_valid && rd_last) && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) check("rd_last_timeout", 0, 1);
   endtask

   task automatic write_vec(input int vr, input int nbeats, output int acc, output int endc);
      int t;
      t = 0;
      @(posedge clk); #1;
      wr_req_valid = 1'b1; wr_req_vr = 5'(vr);
      @(negedge clk);
      while (!wr_req_ready && t < 1000) begin @(negedge clk); t++; end
      if (t >= 1000) check("wr_req_timeout", 0, 1);
      acc = cyc; endc = cyc;
      @(posedge clk); #1;
      wr_req_valid = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
         if (b == stall_beat) begin
            wr_valid = 1'b0;
            @(posedge clk); #1;
         end
         wr_valid = 1'b1; wr_data = wdata[b]; wr_be = wbe_a[b];
         t = 0;
         @(negedge clk);
         while (!wr_ready && t < 100) begin @(negedge clk); t++; end
         if (t >= 100) check("wr_ready_timeout", 0, 1);
         endc = cyc;
         @(posedge clk); #1;
      end
      wr_valid = 1'b0; wr_data = '0; wr_be = '0;
   endtask

   task automatic verify_read(input string tag);
      check({tag, "_beats"}, beats_tot - s_beats, 8);
      check({tag, "_last_cnt"}, last_tot - s_last, 1);
      check({tag, "_last_beat"}, last_beat, 7);
      check({tag, "_beat_order"}, bbad_tot - s_bbad, 0);
      for (int k = 0; k < 8; k++) check($sformatf("%s_data%0d", tag, k), cap[k], expd[k]);
   endtask

   int ra, rw, wa, we;

   initial begin
      rst = 1'b1;
      rd_req_valid = 1'b1; rd_req_vr = '0;
      wr_req_valid = 1'b1; wr_req_vr = 5'd1;
      wr_valid = 1'b1; wr_data = '1; wr_be = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rd_req_ready", rd_req_ready, 0);
      check("rst_wr_req_ready", wr_req_ready, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_last", rd_last, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_rd_beat", rd_beat, 0);
      check("rst_wr_done", wr_done, 0);
      @(posedge clk); #1;
      rd_req_valid = 1'b0; wr_req_valid = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_be = '0;
      rst = 1'b0; mon_en = 1;
`ifdef VRF_RESET_CLEAR_EN
      begin
         int t;
         t = 0;
         @(negedge clk);
         while (!rd_req_ready && t < 1000) begin @(negedge clk); t++; end
         check("clear_ready_low_cycles", t, 256);
         for (int k = 0; k < 8; k++) expd[k] = '0;
         snap();
         read_vec(31, ra, rw);
         @(negedge clk);
         verify_read("clear_vr31");
      end
`else
      @(negedge clk);
      check("ready_after_rst", {rd_req_ready, wr_req_ready}, 2'b11);
`endif

      // Full write with a one-cycle wr_valid gap, then readback
      set_pat(32'd1);
      stall_beat = 4;
      snap();
      write_vec(3, 8, wa, we);
      stall_beat = -1;
      repeat (3) @(posedge clk);
      check("vr3_wr_done_pulses", done_tot - s_done, 1);
      for (int k = 0; k < 8; k++) expd[k] = {4{32'(k + 1)}};
      snap();
      read_vec(3, ra, rw);
      @(negedge clk);
      verify_read("vr3");

      // Partial byte-enable rewrite of beat 2
      set_pat(32'hAAAAAAAA);
      for (int k = 0; k < 8; k++) wdata[k] = {4{32'hAAAAAAAA}};
      write_vec(5, 8, wa, we);
      for (int k = 0; k < 8; k++) begin
         wdata[k] = {4{32'h11111111}};
         wbe_a[k] = (k == 2) ? 4'b0101 : 4'b0000;
      end
      write_vec(5, 8, wa, we);
      read_vec(5, ra, rw);
      @(negedge clk);
      check("vr5_beat2_merge", cap[2], 128'hAAAAAAAA_11111111_AAAAAAAA_11111111);
      check("vr5_beat3_kept", cap[3], {4{32'hAAAAAAAA}});

      // Read of a VR mid-write waits for the write to finish
      set_pat(32'h70000000);
      for (int k = 0; k < 8; k++) expd[k] = wdata[k];
      fork
         write_vec(7, 8, wa, we);
         begin
            repeat (3) @(posedge clk);
            snap();
            read_vec(7, ra, rw);
         end
      join
      @(negedge clk);
      check("vr7_rd_waited", rw > 0, 1);
      check("vr7_rd_accept_cycle", ra, we + 1);
      verify_read("vr7");

      // Concurrent read VR1 / write VR2
      set_pat(32'h10000000);
      for (int k = 0; k < 8; k++) expd[k] = wdata[k];
      write_vec(1, 8, wa, we);
      set_pat(32'h20000000);
      repeat (2) @(posedge clk);
      snap();
      fork
         read_vec(1, ra, rw);
         write_vec(2, 8, wa, we);
      join
      repeat (3) @(posedge clk);
      check("conc_same_accept", ra, wa);
      check("conc_rd_last_cycle", last_cyc, ra + 9);
      check("conc_wr_end_cycle", we, wa + 8);
      check("conc_wr_done", done_tot - s_done, 1);
      verify_read("conc_vr1_old");
      for (int k = 0; k < 8; k++) expd[k] = wdata[k];
      snap();
      read_vec(2, ra, rw);
      @(negedge clk);
      verify_read("conc_vr2_new");

      // Same-cycle read and write of VR9: read first
      set_pat(32'h90000000);
      for (int k = 0; k < 8; k++) expd[k] = wdata[k];
      write_vec(9, 8, wa, we);
      set_pat(32'h99000000);
      snap();
      fork
         read_vec(9, ra, rw);
         write_vec(9, 8, wa, we);
      join
      @(negedge clk);
      check("vr9_wr_after_read", wa, ra + 9);
      check("vr9_wr_at_rd_last", wa, last_cyc);
      verify_read("vr9_old");
      for (int k = 0; k < 8; k++) expd[k] = wdata[k];
      snap();
      read_vec(9, ra, rw);
      @(negedge clk);
      verify_read("vr9_new");

`ifndef VRF_RESET_CLEAR_EN
      // Reset aborts a write after three beats; committed rows keep their data
      set_pat(32'h44000000);
      write_vec(4, 3, wa, we);
      rst = 1'b1;
      @(negedge clk);
      check("abort_wr_ready_in_rst", wr_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_wr_idle", {wr_ready, wr_req_ready}, 2'b01);
      read_vec(4, ra, rw);
      @(negedge clk);
      for (int k = 0; k < 3; k++) check($sformatf("abort_vr4_data%0d", k), cap[k], wdata[k]);

      // Reset aborts an in-flight read
      @(posedge clk); #1;
      rd_req_valid = 1'b1; rd_req_vr = 5'd4;
      @(posedge clk); #1;
      rd_req_valid = 1'b0;
      repeat (2) @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      snap();
      @(negedge clk);
      check("abort_rd_valid", {rd_valid, rd_last}, 2'b00);
      repeat (12) @(posedge clk);
      check("abort_rd_no_beats", beats_tot - s_beats, 0);
`endif

      check("rd_data_zero_when_idle", zero_bad, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
